// File: rtl/edge_evt_pkg.sv
// Shared defaults and sizing helper for the edge event collector.
package edge_evt_pkg;

    localparam int TS_W_DEF  = 16;
    localparam int CNT_W_DEF = 16;
    localparam int DEPTH_DEF = 4;

    // Occupancy needs one bit more than the pointers to represent "full".
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/evt_ts_fifo.sv
// First-word-fall-through timestamp FIFO with occupancy counter.
// The output keeps the last popped word while empty.
module evt_ts_fifo
    import edge_evt_pkg::*;
#(
    parameter int W     = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk2,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PW    = $clog2(DEPTH);
    localparam int LVL_W = lvl_w(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [W-1:0]     hold_q, hold_d;
    logic             pop_ok;

    assign empty  = (level_q == '0);
    assign full   = (level_q == LVL_W'(DEPTH));
    assign pop_ok = pop & ~empty;
    assign level  = level_q;
    assign dout   = empty ? hold_q : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        hold_d   = hold_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            hold_d   = mem_q[rd_ptr_q];
        end
        case ({push, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk2 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            hold_q   <= hold_d;
        end
    end

    // Storage needs no reset: the output mux never exposes an unwritten slot.
    always_ff @(posedge clk2) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/edge_event_collector.sv
// Rising-edge consumer in the clk2 domain: event pulse, timestamp FIFO,
// saturating event count and sticky drop flag.
module edge_event_collector
    import edge_evt_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk2,
    input  logic                   reset_n,
    input  logic                   sync_level,
    input  logic                   clr_stat,
    output logic                   ev_pulse,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [TS_W-1:0]        ev_ts,
    output logic [CNT_W-1:0]       ev_count,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifo_level
);

    logic             lvl_q, lvl_d;
    logic [TS_W-1:0]  ts_cnt_q, ts_cnt_d;
    logic             ev_pulse_q, ev_pulse_d;
    logic [CNT_W-1:0] ev_count_q, ev_count_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] cnt_base;
    logic             rise, pop, push, drop, full, empty;

    assign rise = sync_level & ~lvl_q;
    assign pop  = ~empty & ev_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push = rise & (~full | pop);
    assign drop = rise & full & ~pop;

    always_comb begin
        lvl_d      = sync_level;
        ts_cnt_d   = ts_cnt_q + TS_W'(1);
        ev_pulse_d = rise;
        // Clear first, then apply this cycle's event on top of it.
        cnt_base   = clr_stat ? '0 : ev_count_q;
        ev_count_d = cnt_base;
        if (rise && (cnt_base != '1)) ev_count_d = cnt_base + CNT_W'(1);
        overflow_d = (overflow_q & ~clr_stat) | drop;
    end

    always_ff @(posedge clk2 or negedge reset_n) begin
        if (!reset_n) begin
            lvl_q      <= 1'b1;
            ts_cnt_q   <= '0;
            ev_pulse_q <= 1'b0;
            ev_count_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            lvl_q      <= lvl_d;
            ts_cnt_q   <= ts_cnt_d;
            ev_pulse_q <= ev_pulse_d;
            ev_count_q <= ev_count_d;
            overflow_q <= overflow_d;
        end
    end

    evt_ts_fifo #(.W(TS_W), .DEPTH(DEPTH)) u_fifo (
        .clk2    (clk2),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (ts_cnt_q),
        .dout    (ev_ts),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    assign ev_valid = ~empty;
    assign ev_pulse = ev_pulse_q;
    assign ev_count = ev_count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_edge_event_collector.sv
// Bench for edge_event_collector: directed scenarios plus a random run
// against a queue-based reference model (default parameters), and a
// narrow 4-bit instance for saturation, wrap and async reset.
module tb_edge_event_collector;

    logic clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    int n_chk  = 0;
    int n_fail = 0;

    // Instance A: default parameters
    logic        rst_a, a_sl, a_clr, a_rdy;
    logic        a_pulse, a_valid, a_ovf;
    logic [15:0] a_ts, a_cnt;
    logic [2:0]  a_lvl;

    edge_event_collector u_a (
        .clk2(clk2), .reset_n(rst_a), .sync_level(a_sl), .clr_stat(a_clr),
        .ev_pulse(a_pulse), .ev_valid(a_valid), .ev_ready(a_rdy), .ev_ts(a_ts),
        .ev_count(a_cnt), .overflow(a_ovf), .fifo_level(a_lvl)
    );

    // Instance B: 4-bit timestamp and counter
    logic       rst_b, b_sl, b_clr, b_rdy;
    logic       b_pulse, b_valid, b_ovf;
    logic [3:0] b_ts, b_cnt;
    logic [2:0] b_lvl;

    edge_event_collector #(.TS_W(4), .DEPTH(4), .CNT_W(4)) u_b (
        .clk2(clk2), .reset_n(rst_b), .sync_level(b_sl), .clr_stat(b_clr),
        .ev_pulse(b_pulse), .ev_valid(b_valid), .ev_ready(b_rdy), .ev_ts(b_ts),
        .ev_count(b_cnt), .overflow(b_ovf), .fifo_level(b_lvl)
    );

    // Reference model for instance A: a queue of timestamps and plain counters
    bit m_lvl, m_pulse, m_ovf, m_r, m_p, m_f;
    int m_ts, m_cnt, m_last;
    int m_q[$];

    always @(posedge clk2 or negedge rst_a) begin
        if (!rst_a) begin
            m_lvl = 1; m_ts = 0; m_q.delete(); m_cnt = 0; m_ovf = 0; m_pulse = 0; m_last = 0;
        end else begin
            m_r = a_sl && !m_lvl;
            m_p = (m_q.size() > 0) && a_rdy;
            m_f = (m_q.size() == 4);
            if (m_p) m_last = m_q.pop_front();
            if (a_clr) begin m_cnt = 0; m_ovf = 0; end
            if (m_r) begin
                if (m_f && !m_p) m_ovf = 1;
                else m_q.push_back(m_ts);
                if (m_cnt < 65535) m_cnt++;
            end
            m_pulse = m_r;
            m_lvl   = a_sl;
            m_ts    = (m_ts + 1) % 65536;
        end
    end

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    task automatic evt_a();
        a_sl = 1; tick();
        a_sl = 0; tick();
    endtask

    // Leaves reset released just after an edge; the next edge sees ts_cnt = 0.
    task automatic reset_a();
        rst_a = 0; a_sl = 0; a_rdy = 0; a_clr = 0;
        tick();
        rst_a = 1;
    endtask

    task automatic test_reset();
        rst_a = 0; a_sl = 1; a_rdy = 0; a_clr = 0;
        tick();
        n_chk++; if ({a_pulse, a_valid, a_ovf} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {a_pulse, a_valid, a_ovf}); end
        n_chk++; if (a_cnt !== 16'd0 || a_lvl !== 3'd0) begin n_fail++; $display("FAIL reset_cnt_lvl got %0d/%0d want 0/0", a_cnt, a_lvl); end
        n_chk++; if (a_ts !== 16'd0) begin n_fail++; $display("FAIL reset_ts got %0d want 0", a_ts); end
        rst_a = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_chk++; if (a_pulse !== 1'b0 || a_cnt !== 16'd0) begin n_fail++; $display("FAIL high_at_release cyc=%0d pulse=%b cnt=%0d want 0/0", i, a_pulse, a_cnt); end
        end
        a_sl = 0; tick();
        a_sl = 1; tick();
        n_chk++; if (a_pulse !== 1'b1 || a_cnt !== 16'd1) begin n_fail++; $display("FAIL first_rise pulse=%b cnt=%0d want 1/1", a_pulse, a_cnt); end
        tick();
        n_chk++; if (a_pulse !== 1'b0 || a_cnt !== 16'd1) begin n_fail++; $display("FAIL first_rise_once pulse=%b cnt=%0d want 0/1", a_pulse, a_cnt); end
    endtask

    task automatic test_single();
        reset_a();
        a_rdy = 1;
        repeat (5) tick();
        a_sl = 1; tick();
        n_chk++; if (a_pulse !== 1'b1 || a_cnt !== 16'd1) begin n_fail++; $display("FAIL single_pulse pulse=%b cnt=%0d want 1/1", a_pulse, a_cnt); end
        n_chk++; if (a_valid !== 1'b1 || a_ts !== 16'd5) begin n_fail++; $display("FAIL single_head valid=%b ts=%0d want 1/5", a_valid, a_ts); end
        a_sl = 0; tick();
        n_chk++; if (a_pulse !== 1'b0 || a_valid !== 1'b0) begin n_fail++; $display("FAIL single_after pulse=%b valid=%b want 0/0", a_pulse, a_valid); end
        n_chk++; if (a_ts !== 16'd5) begin n_fail++; $display("FAIL single_hold ts=%0d want 5", a_ts); end
        a_rdy = 0;
    endtask

    task automatic test_overflow();
        reset_a();
        tick();
        repeat (5) evt_a();
        n_chk++; if (a_lvl !== 3'd4 || a_ovf !== 1'b1 || a_cnt !== 16'd5) begin n_fail++; $display("FAIL ovf_state lvl=%0d ovf=%b cnt=%0d want 4/1/5", a_lvl, a_ovf, a_cnt); end
        a_rdy = 1;
        for (int j = 0; j < 4; j++) begin
            n_chk++; if (a_valid !== 1'b1 || a_ts !== 16'(1 + 2 * j)) begin n_fail++; $display("FAIL ovf_drain%0d valid=%b ts=%0d want 1/%0d", j, a_valid, a_ts, 1 + 2 * j); end
            tick();
        end
        n_chk++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty valid=%b want 0", a_valid); end
        a_rdy = 0;
    endtask

    task automatic test_full_pop();
        reset_a();
        tick();
        repeat (4) evt_a();
        a_sl = 1; a_rdy = 1; tick();
        n_chk++; if (a_ovf !== 1'b0 || a_lvl !== 3'd4) begin n_fail++; $display("FAIL full_pop ovf=%b lvl=%0d want 0/4", a_ovf, a_lvl); end
        a_sl = 0;
        for (int j = 0; j < 4; j++) begin
            n_chk++; if (a_ts !== 16'(3 + 2 * j)) begin n_fail++; $display("FAIL full_pop_order%0d ts=%0d want %0d", j, a_ts, 3 + 2 * j); end
            tick();
        end
        n_chk++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL full_pop_empty valid=%b want 0", a_valid); end
        a_rdy = 0;
    endtask

    task automatic test_clr();
        reset_a();
        tick();
        repeat (5) evt_a();
        a_rdy = 1; repeat (4) tick();
        a_rdy = 0;
        repeat (2) evt_a();
        n_chk++; if (a_cnt !== 16'd7 || a_ovf !== 1'b1 || a_lvl !== 3'd2) begin n_fail++; $display("FAIL clr_pre cnt=%0d ovf=%b lvl=%0d want 7/1/2", a_cnt, a_ovf, a_lvl); end
        a_sl = 1; a_clr = 1; tick();
        a_sl = 0; a_clr = 0;
        n_chk++; if (a_cnt !== 16'd1 || a_ovf !== 1'b0 || a_lvl !== 3'd3) begin n_fail++; $display("FAIL clr_evt cnt=%0d ovf=%b lvl=%0d want 1/0/3", a_cnt, a_ovf, a_lvl); end
        a_rdy = 1;
        for (int j = 0; j < 3; j++) begin
            n_chk++; if (a_valid !== 1'b1 || a_ts !== 16'(15 + 2 * j)) begin n_fail++; $display("FAIL clr_keep%0d valid=%b ts=%0d want 1/%0d", j, a_valid, a_ts, 15 + 2 * j); end
            tick();
        end
        a_rdy = 0;
    endtask

    task automatic test_random();
        reset_a();
        for (int c = 0; c < 600; c++) begin
            a_sl  = 1'($urandom_range(0, 1));
            a_rdy = ($urandom_range(0, 3) == 0);
            a_clr = ($urandom_range(0, 15) == 0);
            tick();
            n_chk++; if (a_pulse !== m_pulse) begin n_fail++; $display("FAIL rnd_pulse c=%0d got %b want %b", c, a_pulse, m_pulse); end
            n_chk++; if (a_cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt c=%0d got %0d want %0d", c, a_cnt, m_cnt); end
            n_chk++; if (a_ovf !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf c=%0d got %b want %b", c, a_ovf, m_ovf); end
            n_chk++; if (a_lvl !== 3'(m_q.size())) begin n_fail++; $display("FAIL rnd_lvl c=%0d got %0d want %0d", c, a_lvl, m_q.size()); end
            n_chk++; if (a_valid !== (m_q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid c=%0d got %b want %b", c, a_valid, m_q.size() > 0); end
            n_chk++; if (a_ts !== 16'((m_q.size() > 0) ? m_q[0] : m_last)) begin n_fail++; $display("FAIL rnd_ts c=%0d got %0d want %0d", c, a_ts, (m_q.size() > 0) ? m_q[0] : m_last); end
        end
        a_sl = 0; a_rdy = 0; a_clr = 0;
    endtask

    task automatic test_sat_wrap();
        rst_b = 0; b_sl = 0; b_rdy = 1; b_clr = 0;
        tick();
        rst_b = 1;
        tick();
        repeat (20) begin
            b_sl = 1; tick();
            b_sl = 0; tick();
        end
        n_chk++; if (b_cnt !== 4'd15 || b_ovf !== 1'b0) begin n_fail++; $display("FAIL sat_cnt cnt=%0d ovf=%b want 15/0", b_cnt, b_ovf); end
        b_rdy = 0;
        repeat (6) tick();
        b_sl = 1; tick();
        n_chk++; if (b_valid !== 1'b1 || b_ts !== 4'd15 || b_cnt !== 4'd15) begin n_fail++; $display("FAIL wrap_head valid=%b ts=%0d cnt=%0d want 1/15/15", b_valid, b_ts, b_cnt); end
        b_sl = 0; tick();
        b_sl = 1; tick();
        b_sl = 0;
        n_chk++; if (b_lvl !== 3'd2 || b_ts !== 4'd15) begin n_fail++; $display("FAIL wrap_stall lvl=%0d ts=%0d want 2/15", b_lvl, b_ts); end
        b_rdy = 1; tick();
        b_rdy = 0;
        n_chk++; if (b_valid !== 1'b1 || b_ts !== 4'd1) begin n_fail++; $display("FAIL wrap_next valid=%b ts=%0d want 1/1", b_valid, b_ts); end
        #2 rst_b = 0;
        #1;
        n_chk++; if (b_valid !== 1'b0 || b_lvl !== 3'd0) begin n_fail++; $display("FAIL async_rst valid=%b lvl=%0d want 0/0", b_valid, b_lvl); end
        tick();
        rst_b = 1;
    endtask

    initial begin
        rst_a = 0; a_sl = 0; a_clr = 0; a_rdy = 0;
        rst_b = 0; b_sl = 0; b_clr = 0; b_rdy = 0;
        test_reset();
        test_single();
        test_overflow();
        test_full_pop();
        test_clr();
        test_random();
        test_sat_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
